fifo_wr_arbiter: RTL and testbench

Write-side arbiter for the 32-bit `asyncfifo` write port. It runs in the write clock domain and shares the single FIFO write port among `NREQ` requesters. Grants are round-robin, and each grant lasts at most `BURST_MAX` words. It drives `WR`, `EN` and `DataIn` of the FIFO and stalls on `FULL`.

---
 rtl/fifo_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, bursts capped at BURST_MAX words.
// Optional statistics counters are enabled with the FIFO_WR_ARB_STATS_EN macro.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                 wr_clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 fifo_wr,
    output logic                 fifo_en,
    output logic [DW-1:0]        fifo_data,
    input  logic                 fifo_full
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_words,
    output logic [15:0]          stat_stall
`endif
);

    localparam int LW = $clog2(NREQ);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [LW-1:0]   last_reg, last_next;
    logic [BW-1:0]   beat_reg, beat_next;
    logic            fifo_en_reg;

    logic [DW-1:0]   word [NREQ];
    logic            own_req;
    logic            write;
    logic            found;
    logic [LW-1:0]   winner;
    logic [LW:0]     cand_sum;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
            assign word[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // While in BURST the owner index is always last_reg, since last is loaded with the winner.
    assign own_req = req[last_reg];
    assign write   = (state_reg == BURST) && own_req && !fifo_full;

    always_comb begin
        found    = 1'b0;
        winner   = last_reg;
        cand_sum = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_sum = {1'b0, last_reg} + (LW+1)'(i);
            if (cand_sum >= (LW+1)'(NREQ)) begin
                cand_sum = cand_sum - (LW+1)'(NREQ);
            end
            if (!found && req[cand_sum[LW-1:0]]) begin
                found  = 1'b1;
                winner = cand_sum[LW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = BURST;
                    grant_next = NREQ'(1) << winner;
                    last_next  = winner;
                    beat_next  = '0;
                end else begin
                    grant_next = '0;
                end
            end
            BURST: begin
                if (!own_req) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else if (write) begin
                    beat_next = beat_reg + 1'b1;
                    if (beat_reg == BW'(BURST_MAX - 1)) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            last_reg    <= LW'(NREQ - 1);
            beat_reg    <= '0;
            fifo_en_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
            beat_reg    <= beat_next;
            fifo_en_reg <= 1'b1;
        end
    end

    assign req_ack   = write ? grant_reg : '0;
    assign fifo_wr   = write;
    assign fifo_data = write ? word[last_reg] : '0;
    assign grant     = grant_reg;
    assign busy      = (state_reg == BURST);
    assign fifo_en   = fifo_en_reg;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge wr_clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (req_ack[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign stat_words[gi*16 +: 16] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if (state_reg == BURST && own_req && fifo_full && stall_reg != 16'hFFFF) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stat_stall = stall_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter: single requester, round-robin, short burst,
// backpressure and reset mid-burst, with hand-computed expected values per cycle.
module tb_fifo_wr_arbiter;

    logic         wr_clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   req_ack;
    logic [3:0]   grant;
    logic         busy;
    logic         fifo_wr;
    logic         fifo_en;
    logic [31:0]  fifo_data;
    logic         fifo_full;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [63:0]  stat_words;
    logic [15:0]  stat_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(32), .BURST_MAX(4)) dut (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .grant     (grant),
        .busy      (busy),
        .fifo_wr   (fifo_wr),
        .fifo_en   (fifo_en),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_stall(stat_stall)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        req_data[i*32 +: 32] = w;
    endtask

    // Applies one cycle of inputs, checks the combinational and registered outputs mid-cycle,
    // then advances to just after the next rising edge.
    task automatic cyc(input logic [3:0] r, input logic full, input logic [3:0] e_ack,
                       input logic [31:0] e_data, input logic [3:0] e_grant);
        req       = r;
        fifo_full = full;
        #2;
        check("req_ack",   32'(req_ack),   32'(e_ack));
        check("fifo_wr",   32'(fifo_wr),   32'(|e_ack));
        check("fifo_data", fifo_data,      e_data);
        check("grant",     32'(grant),     32'(e_grant));
        check("busy",      32'(busy),      32'(|e_grant));
        check("fifo_en",   32'(fifo_en),   32'd1);
        $display("t=%0t req=%b full=%b ack=%b wr=%b data=%h grant=%b",
                 $time, r, full, req_ack, fifo_wr, fifo_data, grant);
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ack",   32'(req_ack), 32'd0);
        check("rst_wr",    32'(fifo_wr), 32'd0);
        check("rst_data",  fifo_data,    32'd0);
        check("rst_grant", 32'(grant),   32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_en",    32'(fifo_en), 32'd0);
        @(negedge wr_clk);
        rst_n = 1'b1;
        @(posedge wr_clk);
        #1;
        check("rel_en", 32'(fifo_en), 32'd1);
    endtask

    initial begin
        logic [3:0] oh;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Single requester: two bursts of 4 with one idle cycle between.
        do_reset();
        set_word(0, 32'h1111_0001);
        cyc(4'b0001, 1'b0, 4'b0000, 32'h0, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            set_word(0, 32'h1111_0000 + 32'(k));
            cyc(4'b0001, 1'b0, 4'b0001, 32'h1111_0000 + 32'(k), 4'b0001);
        end
        set_word(0, 32'h1111_0005);
        cyc(4'b0001, 1'b0, 4'b0000, 32'h0, 4'b0000);
        for (int k = 5; k <= 8; k++) begin
            set_word(0, 32'h1111_0000 + 32'(k));
            cyc(4'b0001, 1'b0, 4'b0001, 32'h1111_0000 + 32'(k), 4'b0001);
        end
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0000);

        // Round-robin with all requesting: order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, 32'hA000_0000 + 32'(i));
        cyc(4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0000);
        for (int b = 0; b < 5; b++) begin
            oh = 4'(1 << (b % 4));
            for (int k = 0; k < 4; k++) begin
                cyc(4'b1111, 1'b0, oh, 32'hA000_0000 + 32'(b % 4), oh);
            end
            cyc(4'b1111, 1'b0, 4'b0000, 32'h0, 4'b0000);
        end
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0010);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0000);

        // Short burst by requester 2, then search resumes at requester 3.
        do_reset();
        set_word(2, 32'hC2C2_0001);
        cyc(4'b0100, 1'b0, 4'b0000, 32'h0, 4'b0000);
        cyc(4'b0100, 1'b0, 4'b0100, 32'hC2C2_0001, 4'b0100);
        set_word(2, 32'hC2C2_0002);
        cyc(4'b0100, 1'b0, 4'b0100, 32'hC2C2_0002, 4'b0100);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0100);
        set_word(0, 32'h0000_00B0);
        set_word(3, 32'hD3D3_0001);
        cyc(4'b1001, 1'b0, 4'b0000, 32'h0, 4'b0000);
        cyc(4'b1001, 1'b0, 4'b1000, 32'hD3D3_0001, 4'b1000);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b1000);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0000);

        // Backpressure: 3 stall cycles mid-burst, 10 words total from requester 1.
        do_reset();
        set_word(1, 32'hB1B1_0001);
        cyc(4'b0010, 1'b0, 4'b0000, 32'h0, 4'b0000);
        cyc(4'b0010, 1'b0, 4'b0010, 32'hB1B1_0001, 4'b0010);
        set_word(1, 32'hB1B1_0002);
        cyc(4'b0010, 1'b0, 4'b0010, 32'hB1B1_0002, 4'b0010);
        set_word(1, 32'hB1B1_0003);
        for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b1, 4'b0000, 32'h0, 4'b0010);
        cyc(4'b0010, 1'b0, 4'b0010, 32'hB1B1_0003, 4'b0010);
        set_word(1, 32'hB1B1_0004);
        cyc(4'b0010, 1'b0, 4'b0010, 32'hB1B1_0004, 4'b0010);
        set_word(1, 32'hB1B1_0005);
        cyc(4'b0010, 1'b0, 4'b0000, 32'h0, 4'b0000);
        for (int k = 5; k <= 8; k++) begin
            set_word(1, 32'hB1B1_0000 + 32'(k));
            cyc(4'b0010, 1'b0, 4'b0010, 32'hB1B1_0000 + 32'(k), 4'b0010);
        end
        set_word(1, 32'hB1B1_0009);
        cyc(4'b0010, 1'b0, 4'b0000, 32'h0, 4'b0000);
        for (int k = 9; k <= 10; k++) begin
            set_word(1, 32'hB1B1_0000 + 32'(k));
            cyc(4'b0010, 1'b0, 4'b0010, 32'hB1B1_0000 + 32'(k), 4'b0010);
        end
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0010);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0000);
`ifdef FIFO_WR_ARB_STATS_EN
        check("stat_words0", 32'(stat_words[15:0]),  32'd0);
        check("stat_words1", 32'(stat_words[31:16]), 32'd10);
        check("stat_words2", 32'(stat_words[47:32]), 32'd0);
        check("stat_words3", 32'(stat_words[63:48]), 32'd0);
        check("stat_stall",  32'(stat_stall),        32'd3);
`endif

        // Reset mid-burst after 2 of 4 words; requester 0 wins first afterwards.
        do_reset();
        set_word(0, 32'hE0E0_0001);
        set_word(3, 32'hE3E3_0001);
        cyc(4'b1001, 1'b0, 4'b0000, 32'h0, 4'b0000);
        cyc(4'b1001, 1'b0, 4'b0001, 32'hE0E0_0001, 4'b0001);
        cyc(4'b1001, 1'b0, 4'b0001, 32'hE0E0_0001, 4'b0001);
        do_reset();
        cyc(4'b1001, 1'b0, 4'b0001, 32'hE0E0_0001, 4'b0001);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0001);
        cyc(4'b0000, 1'b0, 4'b0000, 32'h0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
